// File: rtl/famicom_joypad.sv
// famicom_joypad: 4021-style serial pad responder for the Famicom/NES port.
// The CPU's latch strobe (OUT_0) loads the button state and each rising edge
// of the port read strobe (CUP) shifts one bit onto DOUT, which is active-low
// (0 = pressed). Buttons are debounced, and A/B can optionally run in turbo.
//
// Strobe protocol: OUT_0 high means load (parallel, every clock, and CUP is
// ignored). OUT_0 low means shift: every CUP low->high transition moves the
// next bit onto DOUT. Both strobes are asynchronous. They are seen two clocks
// late and act on the third rising CLK edge after the pin change.
module famicom_joypad #(
  parameter int DEB_DIV   = 65536,
  parameter int TURBO_DIV = 357955
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       OUT_0,
  input  logic       CUP,
  input  logic [7:0] BTN,
  input  logic       TURBO_A,
  input  logic       TURBO_B,
  output logic       DOUT,
  output logic [3:0] BITCNT
);

  localparam int DEB_W   = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam int TURBO_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_DIV - 1);
  localparam logic [TURBO_W-1:0] TURBO_LAST = TURBO_W'(TURBO_DIV - 1);

  logic               out0_s1, out0_s2;
  logic               cup_s1, cup_s2, cup_prev;
  logic               cup_rise;
  logic [DEB_W-1:0]   deb_cnt;
  logic [TURBO_W-1:0] turbo_cnt;
  logic [7:0]         samp;
  logic [7:0]         db;
  logic [7:0]         same;
  logic               tph;
  logic [7:0]         eff;
  logic [7:0]         sr;
  logic [3:0]         bit_cnt;

  // Two-flop synchronizers for both strobes, plus a history flop on CUP for
  // rising-edge detection. CUP idles high, so its chain resets to 1 and a
  // spurious edge is not seen after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out0_s1  <= 1'b0;
      out0_s2  <= 1'b0;
      cup_s1   <= 1'b1;
      cup_s2   <= 1'b1;
      cup_prev <= 1'b1;
    end else begin
      out0_s1  <= OUT_0;
      out0_s2  <= out0_s1;
      cup_s1   <= CUP;
      cup_s2   <= cup_s1;
      cup_prev <= cup_s2;
    end
  end

  assign cup_rise = cup_s2 & ~cup_prev;

  // Bits whose new sample agrees with the previous sample are accepted.
  assign same = ~(BTN ^ samp);

  // Debounce: sample BTN every DEB_DIV clocks; a bit is accepted only after
  // two consecutive samples agree.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      deb_cnt <= '0;
      samp    <= 8'h00;
      db      <= 8'h00;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt <= '0;
      samp    <= BTN;
      db      <= (BTN & same) | (db & ~same);
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // Turbo phase: toggles every TURBO_DIV clocks, giving a 2*TURBO_DIV period.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      turbo_cnt <= '0;
      tph       <= 1'b1;
    end else if (turbo_cnt == TURBO_LAST) begin
      turbo_cnt <= '0;
      tph       <= ~tph;
    end else begin
      turbo_cnt <= turbo_cnt + TURBO_W'(1);
    end
  end

  // Effective button state: A and B are gated by the turbo phase when enabled.
  assign eff = {db[7:2],
                db[1] & (~TURBO_B | tph),
                db[0] & (~TURBO_A | tph)};

  // Shift register: load has priority over shift; after eight shifts zeros
  // fill in, so the CPU reads 1s like a stock pad. Holds between edges.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr      <= 8'hFF;
      bit_cnt <= 4'd0;
    end else if (out0_s2) begin
      sr      <= ~eff;
      bit_cnt <= 4'd0;
    end else if (cup_rise) begin
      sr      <= {1'b0, sr[7:1]};
      if (bit_cnt != 4'd8) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  assign DOUT   = sr[0];
  assign BITCNT = bit_cnt;

endmodule
